fifo_ext: RTL

Parametrised successor to the basic single-port-pair FIFO used between RTLinf pipeline stages. It keeps the combinational head and next_read handshake, and adds the following:
- depths that are not a power of two
- runtime-programmable almost-full/almost-empty thresholds
- an occupancy output
- synchronous flush
- a peak-occupancy (high-water) register
- sticky overflow/underflow error flags

It is used wherever stage-to-stage buffering needs back-pressure tuning and debug visibility.

---
 rtl/fifo_ext_if.sv | 35 +++
 rtl/fifo_ext.sv | 87 ++++++++
 2 files changed

// File: rtl/fifo_ext_if.sv
// Handshake bundle between a producer/consumer and fifo_ext.
// The master drives writes, pops, thresholds and control; the slave is the FIFO.
interface fifo_ext_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int LOG_NUM_SLOTS = 4
);
    logic                     flush;
    logic [DATA_WIDTH-1:0]    data_write;
    logic                     write;
    logic                     full;
    logic                     almost_full;
    logic [DATA_WIDTH-1:0]    data_read;
    logic                     next_read;
    logic                     empty;
    logic                     almost_empty;
    logic [LOG_NUM_SLOTS:0]   af_level;
    logic [LOG_NUM_SLOTS:0]   ae_level;
    logic [LOG_NUM_SLOTS:0]   count;
    logic [LOG_NUM_SLOTS:0]   max_count;
    logic                     overflow;
    logic                     underflow;
    logic                     clear_stats;

    modport master (
        output flush, data_write, write, next_read, af_level, ae_level, clear_stats,
        input  full, almost_full, data_read, empty, almost_empty, count, max_count,
               overflow, underflow
    );

    modport slave (
        input  flush, data_write, write, next_read, af_level, ae_level, clear_stats,
        output full, almost_full, data_read, empty, almost_empty, count, max_count,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_ext.sv
// Single-clock FIFO with non-power-of-two depth, programmable almost-full/empty
// thresholds, occupancy and high-water reporting, flush and sticky error flags.
// Head data is combinational from memory; there is no write-to-read bypass.
module fifo_ext #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SLOTS     = 16,
    parameter int LOG_NUM_SLOTS = 4
) (
    input logic        clk,
    input logic        rst,
    fifo_ext_if.slave  bus
);
    localparam int CW = LOG_NUM_SLOTS + 1;

    logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] rd_ptr;
    logic [LOG_NUM_SLOTS-1:0] wr_ptr;
    logic [CW-1:0]            count;
    logic [CW-1:0]            max_count;
    logic                     overflow;
    logic                     underflow;

    logic                     rd_acc;
    logic                     wr_acc;
    logic [CW-1:0]            count_next;
    logic [CW-1:0]            peak_next;
    logic [LOG_NUM_SLOTS-1:0] rd_ptr_inc;
    logic [LOG_NUM_SLOTS-1:0] wr_ptr_inc;

    // Status flags are pure decodes of the count register and thresholds.
    assign bus.empty        = (count == '0);
    assign bus.full         = (count == CW'(NUM_SLOTS));
    assign bus.almost_full  = (count >= bus.af_level);
    assign bus.almost_empty = (count <= bus.ae_level);
    assign bus.count        = count;
    assign bus.max_count    = max_count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
    assign bus.data_read    = mem[rd_ptr];

    // A write into a full FIFO is only safe when the head leaves in the same cycle.
    assign rd_acc = bus.next_read & ~bus.empty;
    assign wr_acc = bus.write & (~bus.full | rd_acc);

    // Pointer increment, occupancy update and running peak.
    always_comb begin
        rd_ptr_inc = (rd_ptr == LOG_NUM_SLOTS'(NUM_SLOTS - 1)) ? '0 : rd_ptr + 1'b1;
        wr_ptr_inc = (wr_ptr == LOG_NUM_SLOTS'(NUM_SLOTS - 1)) ? '0 : wr_ptr + 1'b1;
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        peak_next = (count_next > max_count) ? count_next : max_count;
    end

    // Storage array, written only on accepted writes outside reset/flush.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_acc) begin
            mem[wr_ptr] <= bus.data_write;
        end
    end

    // Pointers, occupancy and sticky statistics; flush keeps the statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_acc) rd_ptr <= rd_ptr_inc;
            if (wr_acc) wr_ptr <= wr_ptr_inc;
            count     <= count_next;
            max_count <= bus.clear_stats ? count_next : peak_next;
            overflow  <= (bus.write & ~wr_acc) | (overflow & ~bus.clear_stats);
            underflow <= (bus.next_read & bus.empty) | (underflow & ~bus.clear_stats);
        end
    end
endmodule
